block_dispatcher: RTL and testbench
===================================

BLOCK_DISPATCHER -- requirements
Module: block_dispatcher

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 arst_n  input  1  reset; asynchronous, active-low.
REQ-003 i_halt  input  1  freeze; when 1, no register updates.
REQ-004 i_block_data  input  320  filled block from the memory controller; word k occupies bits [40k+39:40k], k=0..7.
REQ-005 i_block_data_valid  input  1  level signal; it may stay high for many cycles after a fill.
REQ-006 i_miss_addr  input  16  missed fetch address; [15:3] is the block address and [2:0] is the word offset.
REQ-007 i_miss_addr_valid  input  1  qualifies i_miss_addr.
REQ-008 i_arr_wr_ready  input  1  cache array accepts a write this cycle.
REQ-009 i_user_ready  input  1  user accepts readout this cycle.
REQ-010 o_arr_wr_en  output  1  array write request.
REQ-011 o_arr_wr_addr  output  13  array block address.
REQ-012 o_arr_wr_data  output  320  array write data.
REQ-013 o_arr_wr_parity  output  8  per-word even parity; see Configuration.
REQ-014 o_user_data  output  40  critical word.
REQ-015 o_user_data_valid  output  1  o_user_data is valid.
REQ-016 o_busy  output  1  the block is not in IDLE.
REQ-017 o_done  output  1  one-cycle pulse to the control unit when dispatch completes.

Function
REQ-018 The FSM shall have three states: IDLE=0, WRITE=1, READOUT=2; any other encoding shall go to IDLE.
REQ-019 A start event shall be a rising edge of i_block_data_valid, detected against a registered copy of it, while i_miss_addr_valid=1.
REQ-020 In IDLE, a start event shall capture i_block_data, i_miss_addr[15:3] and i_miss_addr[2:0] into internal registers and move to WRITE on the next edge.
REQ-021 A level-high i_block_data_valid with no rising edge shall not start a dispatch.
REQ-022 A rising edge with i_miss_addr_valid=0 shall be ignored.
REQ-023 In WRITE: o_arr_wr_en=1, o_arr_wr_addr=captured block address, o_arr_wr_data=captured block.
REQ-024 WRITE shall hold until i_arr_wr_ready=1, then move to READOUT on that edge; the write counts as accepted in exactly that cycle.
REQ-025 In READOUT: o_user_data_valid=1, o_user_data=captured word selected by the offset (offset 0 gives bits [39:0], offset 7 gives bits [319:280]).
REQ-026 READOUT shall hold until i_user_ready=1; on that edge the FSM moves to IDLE and o_done pulses high for the following cycle only.
REQ-027 Minimum dispatch latency shall be 3 cycles from the start edge to o_done (1 cycle capture, 1 cycle WRITE, 1 cycle READOUT, with both readies high).
REQ-028 Start events arriving outside IDLE shall be ignored and not queued.
REQ-029 The edge-detect register shall still update in every non-halted cycle, so a valid that stays high does not retrigger after return to IDLE.
REQ-030 Outside WRITE, o_arr_wr_en=0 and o_arr_wr_addr/o_arr_wr_data=0.
REQ-031 Outside READOUT, o_user_data_valid=0 and o_user_data=0.
REQ-032 While i_halt=1, state, captured data, edge register and o_done shall hold their values; combinational outputs shall follow the held state.
REQ-033 While i_halt=1, an acceptance (ready high) shall not advance the FSM.
REQ-034 o_busy shall be 1 exactly when the state is not IDLE.

Reset
REQ-035 arst_n=0 shall immediately force state IDLE, all capture registers 0, the edge register 0 and o_done 0.
REQ-036 As a result, all outputs shall read 0 during reset.
REQ-037 A reset in WRITE or READOUT shall abandon the dispatch, with no o_done pulse.
REQ-038 If i_block_data_valid is already high when reset releases, the first sampled high level counts as a rising edge.

Configuration
REQ-039 Macro DISPATCH_PARITY_EN defined: in WRITE, o_arr_wr_parity[k] shall be the XOR of word k of the captured block; outside WRITE it shall be 0.
REQ-040 Macro DISPATCH_PARITY_EN undefined: o_arr_wr_parity shall be tied to 8'h00 with no parity logic; all other behaviour is unchanged.

Verification
REQ-041 Block with word k = 40'h10+k, addr 16'h1235, both readies high -> WRITE with addr 13'h0246, then READOUT with o_user_data=40'h15, o_done 3 cycles after the edge.
REQ-042 i_arr_wr_ready low for 4 cycles -> o_arr_wr_en held 5 cycles with stable data; READOUT follows the accepting edge.
REQ-043 i_block_data_valid held high for 20 cycles -> exactly one dispatch and one o_done pulse.
REQ-044 i_halt=1 for 3 cycles during READOUT with i_user_ready=1 -> the state stays READOUT and o_done is delayed by 3 cycles.
REQ-045 arst_n pulsed low in WRITE -> outputs 0 immediately, no o_done, and the next start edge dispatches normally.
REQ-046 With DISPATCH_PARITY_EN, word 3 = 40'h0000000007 -> o_arr_wr_parity[3]=1; without the macro o_arr_wr_parity=8'h00.

Source files
------------

// File: rtl/block_dispatcher.sv
// Block dispatcher: captures a filled cache block on a miss, writes it to the array, then hands the critical word to the user.
// Optional per-word even parity on the array write port is enabled by defining DISPATCH_PARITY_EN.
module block_dispatcher (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_halt,
  input  logic [319:0] i_block_data,
  input  logic         i_block_data_valid,
  input  logic [15:0]  i_miss_addr,
  input  logic         i_miss_addr_valid,
  input  logic         i_arr_wr_ready,
  input  logic         i_user_ready,
  output logic         o_arr_wr_en,
  output logic [12:0]  o_arr_wr_addr,
  output logic [319:0] o_arr_wr_data,
  output logic [7:0]   o_arr_wr_parity,
  output logic [39:0]  o_user_data,
  output logic         o_user_data_valid,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READOUT = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           valid_q;
  logic [319:0]   blk_data;
  logic [12:0]    blk_addr;
  logic [2:0]     word_off;
  logic           done_q;
  logic           done_nxt;
  logic           start;
  logic           capture;
  logic [39:0]    sel_word;

  // Only a fresh fill that coincides with a qualified miss starts a dispatch.
  assign start  = i_block_data_valid & ~valid_q & i_miss_addr_valid;
  assign o_done = done_q;

  // State, edge-detect and done registers; halt freezes all of them.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (!i_halt) begin
      state   <= state_nxt;
      valid_q <= i_block_data_valid;
      done_q  <= done_nxt;
    end else begin
      state   <= state;
      valid_q <= valid_q;
      done_q  <= done_q;
    end
  end

  // Capture registers for the block, its address and the critical-word offset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      blk_data <= 320'd0;
      blk_addr <= 13'd0;
      word_off <= 3'd0;
    end else if (!i_halt && capture) begin
      blk_data <= i_block_data;
      blk_addr <= i_miss_addr[15:3];
      word_off <= i_miss_addr[2:0];
    end else begin
      blk_data <= blk_data;
      blk_addr <= blk_addr;
      word_off <= word_off;
    end
  end

  // Critical-word mux.
  always_comb begin
    sel_word = 40'd0;
    case (word_off)
      3'd0:    sel_word = blk_data[39:0];
      3'd1:    sel_word = blk_data[79:40];
      3'd2:    sel_word = blk_data[119:80];
      3'd3:    sel_word = blk_data[159:120];
      3'd4:    sel_word = blk_data[199:160];
      3'd5:    sel_word = blk_data[239:200];
      3'd6:    sel_word = blk_data[279:240];
      3'd7:    sel_word = blk_data[319:280];
      default: sel_word = 40'd0;
    endcase
  end

  // Next-state and output decode; outputs are zero outside their owning state.
  always_comb begin
    state_nxt         = state;
    capture           = 1'b0;
    done_nxt          = 1'b0;
    o_arr_wr_en       = 1'b0;
    o_arr_wr_addr     = 13'd0;
    o_arr_wr_data     = 320'd0;
    o_user_data       = 40'd0;
    o_user_data_valid = 1'b0;
    o_busy            = 1'b1;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (start) begin
          capture   = 1'b1;
          state_nxt = WRITE;
        end else begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        o_arr_wr_en   = 1'b1;
        o_arr_wr_addr = blk_addr;
        o_arr_wr_data = blk_data;
        if (i_arr_wr_ready) begin
          state_nxt = READOUT;
        end else begin
          state_nxt = WRITE;
        end
      end
      READOUT: begin
        o_user_data_valid = 1'b1;
        o_user_data       = sel_word;
        if (i_user_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = READOUT;
        end
      end
      default: begin
        state_nxt = IDLE;
        o_busy    = 1'b1;
      end
    endcase
  end

`ifdef DISPATCH_PARITY_EN
  function automatic logic [7:0] word_parity(input logic [319:0] blk);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      p[k] = ^blk[40*k +: 40];
    end
    return p;
  endfunction

  // Parity accompanies the write only while the write is presented.
  always_comb begin
    if (state == WRITE) begin
      o_arr_wr_parity = word_parity(blk_data);
    end else begin
      o_arr_wr_parity = 8'h00;
    end
  end
`else
  assign o_arr_wr_parity = 8'h00;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher: directed scenarios plus randomized dispatches
// checked against a transaction-level expectation of each dispatch.
module tb_block_dispatcher;

  logic         clk;
  logic         arst_n;
  logic         i_halt;
  logic [319:0] i_block_data;
  logic         i_block_data_valid;
  logic [15:0]  i_miss_addr;
  logic         i_miss_addr_valid;
  logic         i_arr_wr_ready;
  logic         i_user_ready;
  logic         o_arr_wr_en;
  logic [12:0]  o_arr_wr_addr;
  logic [319:0] o_arr_wr_data;
  logic [7:0]   o_arr_wr_parity;
  logic [39:0]  o_user_data;
  logic         o_user_data_valid;
  logic         o_busy;
  logic         o_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  block_dispatcher dut (
    .clk               (clk),
    .arst_n            (arst_n),
    .i_halt            (i_halt),
    .i_block_data      (i_block_data),
    .i_block_data_valid(i_block_data_valid),
    .i_miss_addr       (i_miss_addr),
    .i_miss_addr_valid (i_miss_addr_valid),
    .i_arr_wr_ready    (i_arr_wr_ready),
    .i_user_ready      (i_user_ready),
    .o_arr_wr_en       (o_arr_wr_en),
    .o_arr_wr_addr     (o_arr_wr_addr),
    .o_arr_wr_data     (o_arr_wr_data),
    .o_arr_wr_parity   (o_arr_wr_parity),
    .o_user_data       (o_user_data),
    .o_user_data_valid (o_user_data_valid),
    .o_busy            (o_busy),
    .o_done            (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] exp_parity(input logic [319:0] d);
    logic [7:0] p;
    p = 8'h00;
`ifdef DISPATCH_PARITY_EN
    for (int k = 0; k < 8; k++) p[k] = ^d[40*k +: 40];
`endif
    return p;
  endfunction

  task automatic expect_idle(input string tag, input logic done);
    check({tag, ".wr_en"},  o_arr_wr_en, 1'b0);
    check({tag, ".wr_addr"}, o_arr_wr_addr, 13'd0);
    check({tag, ".wr_data"}, o_arr_wr_data, 320'd0);
    check({tag, ".parity"}, o_arr_wr_parity, 8'h00);
    check({tag, ".uvalid"}, o_user_data_valid, 1'b0);
    check({tag, ".udata"},  o_user_data, 40'd0);
    check({tag, ".busy"},   o_busy, 1'b0);
    check({tag, ".done"},   o_done, done);
  endtask

  task automatic expect_write(input string tag, input logic [319:0] d, input logic [15:0] a);
    check({tag, ".wr_en"},  o_arr_wr_en, 1'b1);
    check({tag, ".wr_addr"}, o_arr_wr_addr, a[15:3]);
    check({tag, ".wr_data"}, o_arr_wr_data, d);
    check({tag, ".parity"}, o_arr_wr_parity, exp_parity(d));
    check({tag, ".uvalid"}, o_user_data_valid, 1'b0);
    check({tag, ".busy"},   o_busy, 1'b1);
    check({tag, ".done"},   o_done, 1'b0);
  endtask

  task automatic expect_readout(input string tag, input logic [39:0] w);
    check({tag, ".wr_en"},  o_arr_wr_en, 1'b0);
    check({tag, ".wr_data"}, o_arr_wr_data, 320'd0);
    check({tag, ".uvalid"}, o_user_data_valid, 1'b1);
    check({tag, ".udata"},  o_user_data, w);
    check({tag, ".busy"},   o_busy, 1'b1);
    check({tag, ".done"},   o_done, 1'b0);
  endtask

  // One complete dispatch: fill edge, WRITE for wr_wait+1 cycles, READOUT stretched by halts and
  // user back-pressure, then a single-cycle done. The fill valid is left high on return.
  task automatic dispatch(input string tag, input logic [319:0] d, input logic [15:0] a,
                          input int wr_wait, input int halt_cyc, input int rd_wait, input bit noisy);
    logic [319:0] dv;
    logic [39:0]  w;
    int           t0;
    dv = d;
    w  = dv[a[2:0]*40 +: 40];
    i_block_data       = d;
    i_miss_addr        = a;
    i_miss_addr_valid  = 1'b1;
    i_block_data_valid = 1'b1;
    i_halt             = 1'b0;
    i_arr_wr_ready     = 1'b0;
    i_user_ready       = 1'b0;
    t0 = cyc;
    tick();
    for (int i = 0; i <= wr_wait; i++) begin
      expect_write({tag, ".write"}, d, a);
      i_block_data   = rand320();
      i_miss_addr    = 16'($urandom);
      i_arr_wr_ready = (i == wr_wait);
      if (noisy) i_block_data_valid = (i == wr_wait) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    for (int h = 0; h < halt_cyc; h++) begin
      expect_readout({tag, ".halted"}, w);
      i_halt       = 1'b1;
      i_user_ready = 1'b1;
      if (noisy) i_block_data_valid = 1'($urandom_range(0, 1));
      tick();
    end
    for (int j = 0; j <= rd_wait; j++) begin
      expect_readout({tag, ".readout"}, w);
      i_halt       = 1'b0;
      i_user_ready = (j == rd_wait);
      if (noisy) i_block_data_valid = (j == rd_wait) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    expect_idle({tag, ".done"}, 1'b1);
    check({tag, ".latency"}, 320'(cyc - t0), 320'(3 + wr_wait + halt_cyc + rd_wait));
    i_user_ready   = 1'b0;
    i_arr_wr_ready = 1'b0;
    tick();
    expect_idle({tag, ".after"}, 1'b0);
  endtask

  task automatic drop_valid();
    i_block_data_valid = 1'b0;
    tick();
    expect_idle("drop", 1'b0);
  endtask

  initial begin
    logic [319:0] blk;
    int           done_cnt;
    arst_n = 1'b0; i_halt = 1'b0; i_block_data = '0; i_block_data_valid = 1'b0;
    i_miss_addr = '0; i_miss_addr_valid = 1'b0; i_arr_wr_ready = 1'b0; i_user_ready = 1'b0;
    #1;
    expect_idle("reset", 1'b0);
    #11;
    arst_n = 1'b1;
    tick();
    expect_idle("post_reset", 1'b0);

    // Reference block: word k = 0x10+k, critical word at offset 5.
    for (int k = 0; k < 8; k++) blk[40*k +: 40] = 40'h10 + 40'(k);
    dispatch("basic", blk, 16'h1235, 0, 0, 0, 1'b0);
    check("basic.addr_calc", 320'(16'h1235 >> 3), 320'h0246);
    drop_valid();

    // Parity case: word 3 = 7 has odd weight.
    blk = '0; blk[159:120] = 40'h0000000007;
    check("parity.word3", 320'(exp_parity(blk)),
`ifdef DISPATCH_PARITY_EN
          320'h08
`else
          320'h00
`endif
    );
    dispatch("parity", blk, 16'h0018, 0, 0, 0, 1'b0);
    drop_valid();

    dispatch("wr_backpressure", rand320(), 16'($urandom), 4, 0, 0, 1'b0);
    drop_valid();
    dispatch("halt_readout", rand320(), 16'($urandom), 0, 3, 0, 1'b0);
    drop_valid();

    // Valid held high for 20 cycles yields one dispatch and one done.
    done_cnt = 0;
    dispatch("held_high", rand320(), 16'($urandom), 0, 0, 0, 1'b0);
    done_cnt++;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_done === 1'b1) done_cnt++;
      check("held_high.busy", o_busy, 1'b0);
    end
    check("held_high.done_count", 320'(done_cnt), 320'd1);
    drop_valid();

    // Rising edge without qualified miss, then level without edge: neither starts.
    i_miss_addr_valid  = 1'b0;
    i_block_data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); expect_idle("no_addr_valid", 1'b0); end
    i_miss_addr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); expect_idle("level_only", 1'b0); end
    drop_valid();

    // Reset while in WRITE abandons the dispatch.
    i_block_data = rand320(); i_miss_addr = 16'($urandom);
    i_miss_addr_valid = 1'b1; i_block_data_valid = 1'b1;
    tick();
    check("rst_write.wr_en", o_arr_wr_en, 1'b1);
    arst_n = 1'b0;
    #1;
    expect_idle("rst_write.async", 1'b0);
    i_block_data_valid = 1'b0;
    tick();
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); expect_idle("rst_write.no_done", 1'b0); end
    dispatch("rst_write.next", rand320(), 16'($urandom), 1, 0, 1, 1'b0);
    drop_valid();

    // Valid already high when reset releases counts as a rising edge.
    arst_n = 1'b0;
    i_block_data_valid = 1'b1; i_miss_addr_valid = 1'b1;
    #1;
    expect_idle("rst_valid_high", 1'b0);
    tick();
    arst_n = 1'b1;
    dispatch("rst_release_edge", rand320(), 16'($urandom), 0, 0, 0, 1'b0);
    drop_valid();

    // Randomized dispatches with ignored start edges while busy.
    for (int n = 0; n < 25; n++) begin
      dispatch("random", rand320(), 16'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
      drop_valid();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
